// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the MAR/MDR memory responder: FSM states, op codes
// and default bus widths.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Index width needed to address 'depth' words (never below one bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with write enable and a registered read port.
// Contents are deliberately not reset.
module mem_array #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32,
  parameter int AW     = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: edge-detected read/write
// strobes, programmable wait states, one-cycle mem_ready completion pulse.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] mdr_data,
  output logic [DATA_W-1:0] m_data_in,
  output logic              mem_ready,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int              AW      = addr_bits(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit              NO_WAIT = (WAIT_STATES == 0);

  // Handshake: a request is accepted on the rising edge where (read|write) is
  // high, was low on the previous edge, and the responder is IDLE; busy covers
  // accept through ACCESS, and mem_ready is high for the single cycle after
  // ACCESS. Strobes seen while busy are dropped, never queued.

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  op_t                 op_q;
  logic                both_q;

  logic                req;
  logic                accept;
  logic                go_access;
  logic                cur_rd;
  logic [ADDR_W-1:0]   cur_addr;
  logic                we;
  logic                re;
  logic [DATA_W-1:0]   rdata;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  // The RAM read is launched on the edge that enters ACCESS so its registered
  // output is ready to be captured into m_data_in on the ACCESS edge.
  always_comb begin
    req       = read | write;
    accept    = (state == IDLE) && req && !req_q;
    cur_addr  = (state == IDLE) ? mar_addr : addr_q;
    cur_rd    = (state == IDLE) ? (read && !write) : ((op_q == OP_RD) && !both_q);
    go_access = (accept && NO_WAIT) || ((state == WAIT) && (wait_cnt == WS_LAST));
    re        = go_access && cur_rd && in_range(cur_addr);
    we        = (state == ACCESS) && (op_q == OP_WR) && !both_q && in_range(addr_q);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= OP_RD;
      both_q    <= 1'b0;
      m_data_in <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_q     <= req;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q   <= mar_addr;
            data_q   <= mdr_data;
            op_q     <= write ? OP_WR : OP_RD;
            both_q   <= read & write;
            busy     <= 1'b1;
            err      <= 1'b0;
            wait_cnt <= '0;
            state    <= NO_WAIT ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          if (go_access) begin
            wait_cnt <= '0;
            state    <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ACCESS: begin
          if (both_q || !in_range(addr_q)) err <= 1'b1;
          if ((op_q == OP_RD) && !both_q)
            m_data_in <= in_range(addr_q) ? rdata : '0;
          mem_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

  mem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .re   (re),
    .addr (cur_addr[AW-1:0]),
    .wdata(data_q),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (1 wait state / 256 words and
// 3 wait states / 512 words) checked every cycle against a cycle-count model.
module tb_mem_responder;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic [8:0]  addr  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] wdata [2];
  logic [31:0] dout  [2];
  logic        rdy   [2];
  logic        busy  [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_STATES(1)) dut0 (
    .clk(clk), .clr(clr), .mar_addr(addr[0]), .read(rd[0]), .write(wr[0]),
    .mdr_data(wdata[0]), .m_data_in(dout[0]), .mem_ready(rdy[0]), .busy(busy[0]),
    .err(err[0]), .dbg_state(dbg[0]));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_STATES(3)) dut1 (
    .clk(clk), .clr(clr), .mar_addr(addr[1]), .read(rd[1]), .write(wr[1]),
    .mdr_data(wdata[1]), .m_data_in(dout[1]), .mem_ready(rdy[1]), .busy(busy[1]),
    .err(err[1]), .dbg_state(dbg[1]));

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 256 : 512;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  bit          m_acc;
  bit          m_pend [2];
  bit          m_prev [2];
  bit          m_rd   [2];
  bit          m_wr   [2];
  logic [8:0]  m_addr [2];
  logic [31:0] m_data [2];
  int          m_done [2];
  logic        e_rdy  [2];
  logic        e_busy [2];
  logic        e_err  [2];
  logic [31:0] e_dout [2];
  bit          e_known[2];
  logic [31:0] mem_m  [2][512];
  bit          mem_k  [2][512];

  // A request completes WAIT_STATES+1 edges after its accept edge.
  initial forever begin
    @(posedge clk or negedge clr);
    if (!clr) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] = 0; m_prev[k] = 0;
        e_rdy[k] = 0; e_busy[k] = 0; e_err[k] = 0;
        e_dout[k] = '0; e_known[k] = 1;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        m_acc = !m_pend[k] && (rd[k] || wr[k]) && !m_prev[k];
        m_prev[k] = rd[k] || wr[k];
        e_rdy[k] = 0;
        if (m_pend[k] && cyc == m_done[k]) begin
          m_pend[k] = 0; e_rdy[k] = 1; e_busy[k] = 0;
          if (m_rd[k] && m_wr[k]) begin
            e_err[k] = 1;
          end else if (int'(m_addr[k]) >= depth_of(k)) begin
            e_err[k] = 1;
            if (m_rd[k]) begin e_dout[k] = '0; e_known[k] = 1; end
          end else if (m_rd[k]) begin
            e_dout[k] = mem_m[k][m_addr[k]];
            e_known[k] = mem_k[k][m_addr[k]];
          end else begin
            mem_m[k][m_addr[k]] = m_data[k];
            mem_k[k][m_addr[k]] = 1;
          end
        end
        if (m_acc) begin
          m_pend[k] = 1; m_done[k] = cyc + ws_of(k) + 1;
          m_rd[k] = rd[k]; m_wr[k] = wr[k];
          m_addr[k] = addr[k]; m_data[k] = wdata[k];
          e_busy[k] = 1; e_err[k] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mem_ready", k, 32'(rdy[k]), 32'(e_rdy[k]));
      chk("busy", k, 32'(busy[k]), 32'(e_busy[k]));
      chk("err", k, 32'(err[k]), 32'(e_err[k]));
      if (e_known[k]) chk("m_data_in", k, dout[k], e_dout[k]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int k, input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk); #2;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  // lat counts edges after the accept edge until mem_ready is seen high.
  task automatic wait_rdy(input int k, output int lat, output int bc);
    lat = -1; bc = 0;
    for (int n = 0; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (rdy[k]) lat = n;
      else if (busy[k]) bc++;
    end
    if (lat < 0) chk("ready_timeout", k, 32'(rdy[k]), 32'd1);
  endtask

  task automatic xfer(input int k, input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
    int lat, bc;
    issue(k, r, w, a, d);
    wait_rdy(k, lat, bc);
    chk("latency", k, lat, ws_of(k) + 1);
    chk("busy_cycles", k, bc, ws_of(k) + 1);
  endtask

  task automatic read_chk(input int k, input logic [8:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    xfer(k, 1'b1, 1'b0, a, '0);
    chk("read_data", k, dout[k], exp_q.pop_front());
  endtask

  task automatic strobe_pattern(input int k, input logic [8:0] a, input logic [15:0] pat, output int pulses);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #2;
      rd[k] = pat[i]; wr[k] = 1'b0; addr[k] = a;
      @(negedge clk);
      if (rdy[k]) pulses++;
    end
    rd[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat, bc, p;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    #1 clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_data", k, dout[k], 32'h0);
      chk("rst_ready", k, 32'(rdy[k]), 32'd0);
      chk("rst_busy", k, 32'(busy[k]), 32'd0);
      chk("rst_err", k, 32'(err[k]), 32'd0);
      chk("rst_state", k, 32'(dbg[k]), 32'd0);
    end

    // Read of preloaded word, latency two edges with one wait state
    xfer(0, 1'b0, 1'b1, 9'h000, 32'h28918000);
    issue(0, 1'b1, 1'b0, 9'h000, '0);
    wait_rdy(0, lat, bc);
    chk("t1_latency", 0, lat, 32'd2);
    chk("t1_busy", 0, bc, 32'd2);
    chk("t1_data", 0, dout[0], 32'h28918000);

    // Write leaves m_data_in alone, read back returns written word
    xfer(0, 1'b0, 1'b1, 9'h010, 32'h000000FF);
    chk("t2_hold", 0, dout[0], 32'h28918000);
    read_chk(0, 9'h010, 32'h000000FF);
    chk("t2_model", 0, mem_m[0][16], 32'h000000FF);

    // Held strobe and strobes while busy
    xfer(0, 1'b0, 1'b1, 9'h001, 32'h11111111);
    strobe_pattern(0, 9'h001, 16'h001F, p);
    chk("t3_hold_pulses", 0, p, 32'd1);
    chk("t3_data", 0, dout[0], 32'h11111111);
    strobe_pattern(0, 9'h001, 16'h0005, p);
    chk("t3_busy_pulses", 0, p, 32'd1);
    strobe_pattern(0, 9'h001, 16'h0025, p);
    chk("t3_after_done", 0, p, 32'd2);
    strobe_pattern(0, 9'h001, 16'h0009, p);
    chk("t3_back_to_back", 0, p, 32'd2);

    // Simultaneous read and write
    xfer(0, 1'b0, 1'b1, 9'h020, 32'hFFFFFFFF);
    read_chk(0, 9'h010, 32'h000000FF);
    xfer(0, 1'b1, 1'b1, 9'h020, 32'h00000000);
    chk("t4_err", 0, 32'(err[0]), 32'd1);
    chk("t4_hold", 0, dout[0], 32'h000000FF);
    read_chk(0, 9'h020, 32'hFFFFFFFF);
    chk("t4_err_clr", 0, 32'(err[0]), 32'd0);

    // Address beyond DEPTH=256
    xfer(0, 1'b0, 1'b1, 9'h0FF, 32'hCAFEF00D);
    read_chk(0, 9'h1FF, 32'h00000000);
    chk("t5_rd_err", 0, 32'(err[0]), 32'd1);
    xfer(0, 1'b0, 1'b1, 9'h1FF, 32'hDEADBEEF);
    chk("t5_wr_err", 0, 32'(err[0]), 32'd1);
    read_chk(0, 9'h0FF, 32'hCAFEF00D);
    chk("t5_err_clr", 0, 32'(err[0]), 32'd0);

    // Reset during WAIT aborts the write
    xfer(1, 1'b0, 1'b1, 9'h030, 32'hA5A5A5A5);
    read_chk(1, 9'h030, 32'hA5A5A5A5);
    issue(1, 1'b0, 1'b1, 9'h030, 32'h0000000F);
    @(negedge clk);
    chk("t6_in_wait", 1, 32'(dbg[1]), 32'd1);
    chk("t6_busy", 1, 32'(busy[1]), 32'd1);
    @(posedge clk); #3;
    clr = 1'b0;
    #1;
    chk("t6_rst_data", 1, dout[1], 32'h0);
    chk("t6_rst_ready", 1, 32'(rdy[1]), 32'd0);
    chk("t6_rst_busy", 1, 32'(busy[1]), 32'd0);
    chk("t6_rst_err", 1, 32'(err[1]), 32'd0);
    chk("t6_rst_state", 1, 32'(dbg[1]), 32'd0);
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    p = 0;
    repeat (8) begin
      @(negedge clk);
      if (rdy[1]) p++;
    end
    chk("t6_no_ready", 1, p, 32'd0);
    read_chk(1, 9'h030, 32'hA5A5A5A5);
    chk("t6_model", 1, mem_m[1][48], 32'hA5A5A5A5);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
